edge_event_logger: RTL

Consumes the testbench's 1-bit stimulus signals (x, y, a, b, m style) on the free-running `clock` and records every change of the input vector. Each change is stored as a timestamped event in a small FIFO. A reader, either the bench or a monitor, drains the events through a show-ahead valid/read interface. It is the first downstream stage fed directly by the stimulus drivers.

---
 rtl/evlog_pkg.sv | 33 +++
 rtl/evlog_fifo.sv | 57 +++++
 rtl/edge_event_logger.sv | 76 +++++++
 3 files changed

// File: rtl/evlog_pkg.sv
// Shared constants and event-word helpers for the edge event logger.
// An event word is {timestamp, input vector}, timestamp in the upper bits.
package evlog_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int EV_W      = TS_W_DEF + N_IN_DEF;
  localparam int PTR_W     = $clog2(DEPTH_DEF);

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Widths are passed at run time so any instance width can share these helpers.
  function automatic logic [63:0] ev_pack(input logic [31:0] ts, input logic [31:0] vec,
                                          input int n_in);
    logic [63:0] mask;
    mask = (64'd1 << n_in) - 64'd1;
    return ({32'd0, ts} << n_in) | ({32'd0, vec} & mask);
  endfunction

  function automatic logic [31:0] ev_ts(input logic [63:0] word, input int n_in);
    return 32'(word >> n_in);
  endfunction

  function automatic logic [31:0] ev_vec(input logic [63:0] word, input int n_in);
    logic [63:0] mask;
    mask = (64'd1 << n_in) - 64'd1;
    return 32'(word & mask);
  endfunction

endpackage

// File: rtl/evlog_fifo.sv
// Show-ahead FIFO: o_data always presents the head entry, zero when empty.
// When full, a push is still accepted if a pop frees the head slot on the same edge.
module evlog_fifo
  import evlog_pkg::*;
#(
  parameter int W     = EV_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/edge_event_logger.sv
// Synchronises din, detects any change of the vector and logs {ts, vector}
// into a show-ahead FIFO; a sticky flag records events dropped while full.
module edge_event_logger
  import evlog_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_IN-1:0]          din,
  input  logic                     rd_en,
  input  logic                     clear_ovf,
  output logic                     rd_valid,
  output logic [TS_W+N_IN-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int W = TS_W + N_IN;

  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;
  logic [N_IN-1:0] r_prev;
  logic [TS_W-1:0] r_ts;
  logic            r_overflow;
  logic            w_event;
  logic            w_full;
  logic            w_empty;
  logic            w_drop;
  logic [W-1:0]    w_word;

  assign w_event = enable & (r_sync2 != r_prev);
  assign w_word  = W'(ev_pack(32'(r_ts), 32'(r_sync2), N_IN));
  // A full FIFO only loses the event when no pop frees a slot on this edge.
  assign w_drop  = w_event & w_full & ~rd_en;

  // prev tracks sync2 even while disabled so re-enabling never sees a stale edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_ts       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (enable) r_ts <= r_ts + 1'b1;
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
    end
  end

  evlog_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_event),
    .i_pop   (rd_en),
    .i_data  (w_word),
    .o_data  (rd_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign rd_valid = ~w_empty;
  assign overflow = r_overflow;

endmodule
